// File: rtl/truth_table_scanner.sv
// Truth-table scanner: walks all 16 {a,b,c,d} vectors through an external
// combinational block, samples y per vector, and reports table/ones/match.
module truth_table_scanner #(
  parameter int unsigned SETTLE = 1,
  parameter logic [15:0] EXPECT = 16'h0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        y,
  output logic        a,
  output logic        b,
  output logic        c,
  output logic        d,
  output logic        busy,
  output logic        done,
  output logic [15:0] truth_table,
  output logic [4:0]  ones,
  output logic        match
);

  localparam int unsigned IDX_W  = 4;
  localparam int unsigned CNT_W  = 4;
  localparam int unsigned ONES_W = 5;
  localparam int unsigned TBL_W  = 16;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_SCAN = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [CNT_W-1:0] SETTLE_C = CNT_W'(SETTLE);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(15);

  logic [1:0]        state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [TBL_W-1:0]  table_q, table_d;
  logic [ONES_W-1:0] ones_q, ones_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              match_q, match_d;
  logic [TBL_W-1:0]  table_upd;

  // Next-state and registered-output logic
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    cnt_d     = cnt_q;
    table_d   = table_q;
    ones_d    = ones_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    match_d   = match_q;
    table_upd = table_q;
    table_upd[idx_q] = y;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_SCAN;
          idx_d   = '0;
          cnt_d   = '0;
          table_d = '0;
          ones_d  = '0;
          busy_d  = 1'b1;
          match_d = 1'b0;
        end
      end
      S_SCAN: begin
        if (cnt_q == SETTLE_C) begin
          table_d = table_upd;
          ones_d  = ones_q + ONES_W'(y);
          cnt_d   = '0;
          if (idx_q == LAST_IDX) begin
            state_d = S_DONE;
            idx_d   = '0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            match_d = (table_upd == EXPECT);
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      table_q <= '0;
      ones_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      match_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      table_q <= table_d;
      ones_q  <= ones_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      match_q <= match_d;
    end
  end

  assign a           = idx_q[3];
  assign b           = idx_q[2];
  assign c           = idx_q[1];
  assign d           = idx_q[0];
  assign busy        = busy_q;
  assign done        = done_q;
  assign truth_table = table_q;
  assign ones        = ones_q;
  assign match       = match_q;

endmodule
